// File: rtl/riscv_pkg.sv
// Shared RISC-V core widths, reset defaults and the fetch bundle type.
// Imported by every front-end stage.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Prefetch bundle: instruction-memory request/response, redirect,
// and the decode-facing instruction handshake.
interface if_prefetch_if;
  import riscv_pkg::*;

  logic               imem_req_o;
  logic [XLEN-1:0]    imem_addr_o;
  logic               imem_gnt_i;
  logic               imem_rvalid_i;
  logic [INSTR_W-1:0] imem_rdata_i;
  logic               redirect_i;
  logic [XLEN-1:0]    redirect_pc_i;
  logic               instr_valid_o;
  logic [INSTR_W-1:0] instr_data_o;
  logic [XLEN-1:0]    instr_pc_o;
  logic               instr_ready_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output instr_valid_o, instr_data_o, instr_pc_o,
    input  instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  instr_valid_o, instr_data_o, instr_pc_o,
    output instr_ready_i
  );

endinterface

// File: rtl/if_prefetch_fifo.sv
// fetch_fifo: DEPTH-entry {pc,instr} buffer with flush.
// Push and pop may coincide at any occupancy, including full.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= nxt(wp);
      end
      if (do_pop) begin
        rp <= nxt(rp);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Empty head reads as zero so stale entries never leak out.
  assign head = empty ? '0 : mem[rp];

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetcher with in-order response tagging,
// redirect flush and discard of in-flight responses.
module if_prefetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic clk,
  input  logic rst,
  if_prefetch_if.master bus
);

  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   buffered;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW:0]     after_pop;
  logic [CW:0]     in_use;
  logic [CW:0]     disc_sum;
  logic            req;
  logic            grant;
  logic            rsp_live;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  fetch_entry_t    wdata;
  fetch_entry_t    head;

  assign pop = ~empty & bus.instr_ready_i;

  // A slot freed by this cycle's pop may be refilled right away.
  assign after_pop = {1'b0, outstanding} + {1'b0, buffered}
                   - (CW+1)'(pop);
  assign in_use    = {1'b0, outstanding} + {1'b0, discard};

  assign req = ~rst & ~bus.redirect_i
             & (after_pop < LIMIT) & (in_use < LIMIT);

  assign grant    = req & bus.imem_gnt_i;
  assign rsp_live = bus.imem_rvalid_i & (discard == '0);
  assign rsp_drop = bus.imem_rvalid_i & (discard != '0);
  assign push     = rsp_live & ~bus.redirect_i & (~full | pop);

  // On redirect every still-owed response becomes a discard.
  assign disc_sum = {1'b0, discard} + {1'b0, outstanding}
                  + (CW+1)'(grant)
                  - (CW+1)'(rsp_drop) - (CW+1)'(rsp_live);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
      fetch_pc    <= word_align(RESET_PC);
      resp_pc     <= word_align(RESET_PC);
    end else if (bus.redirect_i) begin
      outstanding <= '0;
      discard     <= disc_sum[CW-1:0];
      fetch_pc    <= word_align(bus.redirect_pc_i);
      resp_pc     <= word_align(bus.redirect_pc_i);
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(rsp_live);
      discard     <= discard - CW'(rsp_drop);
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
      end
    end
  end

  assign wdata.pc    = resp_pc;
  assign wdata.instr = bus.imem_rdata_i;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_i),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (buffered)
  );

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc;
  assign bus.instr_valid_o = ~empty;
  assign bus.instr_data_o  = head.instr;
  assign bus.instr_pc_o    = head.pc;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: in-order memory model, stream model of
// expected {pc,data}, directed scenarios and a RESET_PC wrap instance.
module tb_if_prefetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst;
  logic rst2;

  always #5 clk = ~clk;

  if_prefetch_if bus ();
  if_prefetch_if bus2 ();

  if_prefetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  if_prefetch #(
    .RESET_PC (RPC2),
    .DEPTH    (DEPTH)
  ) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory and stream model state
  logic [31:0] pend[$];
  logic [31:0] fired[$];
  logic [31:0] fired_d[$];
  logic        gnt_en;
  logic        rv_hold;
  int          n_gnt;
  int          inflight;
  logic [31:0] exp_pc;
  logic        prev_stall;
  logic [31:0] prev_addr;
  logic        prev_redir;
  logic [31:0] redir_tgt;

  function automatic logic [31:0] fget(input int i);
    if (i < fired.size()) return fired[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dget(input int i);
    if (i < fired_d.size()) return fired_d[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Compare process: checks DUT against the stream model every cycle
  always @(negedge clk) begin
    if (rst) begin
      check("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
      check("rst_valid", {31'b0, bus.instr_valid_o}, 32'd0);
      check("rst_addr", bus.imem_addr_o, 32'h0);
      check("rst_data", bus.instr_data_o, 32'h0);
      check("rst_pc", bus.instr_pc_o, 32'h0);
      exp_pc     = 32'h0;
      inflight   = 0;
      prev_stall = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_stall)
        check("addr_hold", bus.imem_addr_o, prev_addr);
      if (prev_redir) begin
        check("redir_addr", bus.imem_addr_o, redir_tgt);
        check("redir_valid", {31'b0, bus.instr_valid_o}, 32'd0);
      end
      check("addr_align", {30'b0, bus.imem_addr_o[1:0]}, 32'd0);
      check("req_in_redir",
            {31'b0, bus.imem_req_o & bus.redirect_i}, 32'd0);
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        check("stream_pc", bus.instr_pc_o, exp_pc);
        check("stream_data", bus.instr_data_o, memf(exp_pc));
        fired.push_back(bus.instr_pc_o);
        fired_d.push_back(bus.instr_data_o);
        exp_pc = exp_pc + 32'd4;
      end
      if (bus.imem_req_o && bus.imem_gnt_i) begin
        pend.push_back(bus.imem_addr_o);
        inflight++;
        n_gnt++;
      end
      if (bus.imem_rvalid_i) inflight--;
      check("inflight_max", {31'b0, inflight > DEPTH}, 32'd0);
      prev_stall = bus.imem_req_o & ~bus.imem_gnt_i & ~bus.redirect_i;
      prev_addr  = bus.imem_addr_o;
      prev_redir = bus.redirect_i;
      if (bus.redirect_i) begin
        redir_tgt = {bus.redirect_pc_i[31:2], 2'b00};
        exp_pc    = redir_tgt;
      end
    end
  end

  // One cycle: respond in order, apply grant policy, settle
  task automatic step();
    @(posedge clk);
    #1;
    bus.redirect_i = 1'b0;
    bus.imem_gnt_i = gnt_en;
    if (!rst && !rv_hold && pend.size() > 0) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = memf(pend.pop_front());
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'h0;
    end
    #1;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    pend.delete();
    #1;
    check("rst_now_req", {31'b0, bus.imem_req_o}, 32'd0);
    check("rst_now_valid", {31'b0, bus.instr_valid_o}, 32'd0);
    check("rst_now_addr", bus.imem_addr_o, 32'h0);
    check("rst_now_data", bus.instr_data_o, 32'h0);
    check("rst_now_pc", bus.instr_pc_o, 32'h0);
    step();
    step();
    pend.delete();
    fired.delete();
    fired_d.delete();
    n_gnt = 0;
    rst   = 1'b0;
    #1;
  endtask

  // Second instance: RESET_PC near the top of the address space
  logic [31:0] f2[$];
  logic [31:0] d2[$];
  logic        f_done = 1'b0;

  initial begin
    logic        g;
    logic [31:0] a;
    g = 1'b0;
    a = 32'h0;
    rst2 = 1'b0;
    bus2.imem_gnt_i    = 1'b1;
    bus2.imem_rvalid_i = 1'b0;
    bus2.imem_rdata_i  = 32'h0;
    bus2.redirect_i    = 1'b0;
    bus2.redirect_pc_i = 32'h0;
    bus2.instr_ready_i = 1'b1;
    #1 rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus2.instr_valid_o && bus2.instr_ready_i) begin
        f2.push_back(bus2.instr_pc_o);
        d2.push_back(bus2.instr_data_o);
      end
      g = bus2.imem_req_o & bus2.imem_gnt_i;
      a = bus2.imem_addr_o;
      @(posedge clk);
      #1;
      bus2.imem_rvalid_i = g;
      bus2.imem_rdata_i  = g ? memf(a) : 32'h0;
    end
    f_done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gaps;
    rst                = 1'b0;
    gnt_en             = 1'b1;
    rv_hold            = 1'b0;
    n_gnt              = 0;
    inflight           = 0;
    exp_pc             = 32'h0;
    prev_stall         = 1'b0;
    prev_redir         = 1'b0;
    prev_addr          = 32'h0;
    redir_tgt          = 32'h0;
    bus.imem_gnt_i     = 1'b1;
    bus.imem_rvalid_i  = 1'b0;
    bus.imem_rdata_i   = 32'h0;
    bus.redirect_i     = 1'b0;
    bus.redirect_pc_i  = 32'h0;
    bus.instr_ready_i  = 1'b1;
    #1 rst = 1'b1;

    // Free-running stream
    reset_dut();
    gaps = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i >= 2 && !bus.instr_valid_o) gaps++;
    end
    check("a_gaps", 32'(gaps), 32'd0);
    check("a_pc0", fget(0), 32'h0000_0000);
    check("a_pc1", fget(1), 32'h0000_0004);
    check("a_pc2", fget(2), 32'h0000_0008);
    check("a_d1", dget(1), 32'h1357_9BDB);

    // Decode stall with buffer full
    bus.instr_ready_i = 1'b0;
    reset_dut();
    repeat (10) step();
    check("b_grants", 32'(n_gnt), 32'd2);
    check("b_req", {31'b0, bus.imem_req_o}, 32'd0);
    check("b_valid", {31'b0, bus.instr_valid_o}, 32'd1);
    check("b_head_pc", bus.instr_pc_o, 32'h0);
    check("b_head_d", bus.instr_data_o, 32'h1357_9BDF);
    check("b_next_addr", bus.imem_addr_o, 32'h0000_0008);
    bus.instr_ready_i = 1'b1;
    repeat (6) step();
    check("b_pc2", fget(2), 32'h0000_0008);
    check("b_d2", dget(2), 32'h1357_9BD7);

    // Redirect with two requests in flight
    rv_hold = 1'b1;
    reset_dut();
    repeat (3) step();
    check("c_inflight", 32'(inflight), 32'd2);
    check("c_req", {31'b0, bus.imem_req_o}, 32'd0);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0102;
    step();
    check("c_req_post", {31'b0, bus.imem_req_o}, 32'd0);
    rv_hold = 1'b0;
    repeat (10) step();
    check("c_pc0", fget(0), 32'h0000_0100);
    check("c_d0", dget(0), 32'h1357_9ADF);

    // Grant stall, then redirect during the stall
    reset_dut();
    step();
    gnt_en = 1'b0;
    for (int i = 2; i <= 6; i++) begin
      step();
      check("d_addr_stall", bus.imem_addr_o, 32'h0000_0008);
    end
    check("d_req_stall", {31'b0, bus.imem_req_o}, 32'd1);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0200;
    step();
    check("d_addr_redir", bus.imem_addr_o, 32'h0000_0200);
    check("d_pre_pc1", fget(1), 32'h0000_0004);
    fired.delete();
    fired_d.delete();
    gnt_en = 1'b1;
    repeat (8) step();
    check("d_pc0", fget(0), 32'h0000_0200);
    check("d_d0", dget(0), 32'h1357_99DF);

    // Reset with requests in flight
    rv_hold = 1'b1;
    reset_dut();
    repeat (3) step();
    check("e_inflight", 32'(inflight), 32'd2);
    reset_dut();
    rv_hold = 1'b0;
    repeat (8) step();
    check("e_pc0", fget(0), 32'h0000_0000);
    check("e_pc1", fget(1), 32'h0000_0004);
    check("e_d0", dget(0), 32'h1357_9BDF);

    // RESET_PC wrap instance
    check("f_done", {31'b0, f_done}, 32'd1);
    check("f_n", {31'b0, f2.size() >= 3}, 32'd1);
    if (f2.size() >= 3) begin
      check("f_pc0", f2[0], 32'hFFFF_FFF8);
      check("f_pc1", f2[1], 32'hFFFF_FFFC);
      check("f_pc2", f2[2], 32'h0000_0000);
      check("f_d0", d2[0], 32'hECA8_6427);
      check("f_d1", d2[1], 32'hECA8_6423);
      check("f_d2", d2[2], 32'h1357_9BDF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2: instruction buffer entries; also the maximum number of in-flight memory requests.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port imem_req_o  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr_o  output  32  fetch byte address, word-aligned.
REQ-007 SHALL have port imem_gnt_i  input  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid_i  input  1  response data valid; responses return in request order, at least 1 cycle after grant.
REQ-009 SHALL have port imem_rdata_i  input  32  instruction word.
REQ-010 SHALL have port redirect_i  input  1  flush and restart fetch at a new PC.
REQ-011 SHALL have port redirect_pc_i  input  32  restart address.
REQ-012 SHALL have port instr_valid_o  output  1  buffered instruction available.
REQ-013 SHALL have port instr_data_o  output  32  instruction word at buffer head.
REQ-014 SHALL have port instr_pc_o  output  32  PC of instr_data_o.
REQ-015 SHALL have port instr_ready_i  input  1  decode accepts the head instruction.

Function
REQ-016 SHALL drive imem_addr_o from a fetch-PC register; imem_addr_o[1:0] always 0.
REQ-017 SHALL assert imem_req_o whenever (outstanding + buffered) < DEPTH and redirect_i is low.
REQ-018 SHALL, on imem_req_o & imem_gnt_i, increment fetch-PC by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0) and increment the outstanding count.
REQ-019 SHALL hold imem_addr_o stable while imem_req_o is high and imem_gnt_i is low, except on redirect.
REQ-020 SHALL, on imem_rvalid_i with no discard pending, push {pc, rdata} into the buffer and decrement the outstanding count; the tag PC is tracked by a separate response-PC register advancing by 4 per push.
REQ-021 SHALL present the buffer head on instr_valid_o, instr_data_o, instr_pc_o; pop on instr_valid_o & instr_ready_i.
REQ-022 SHALL allow push and pop in the same cycle at any occupancy, including full.
REQ-023 SHALL have zero-cycle bypass disabled: an instruction is visible on outputs the cycle after its rvalid.
REQ-024 SHALL, on redirect_i: empty the buffer, load fetch-PC and response-PC with {redirect_pc_i[31:2],2'b00}, and move all outstanding requests (including one granted the same cycle) into a discard counter.
REQ-025 SHALL drop responses while the discard counter is nonzero, decrementing it per rvalid; no push occurs.
REQ-026 SHALL deassert instr_valid_o in the cycle after redirect_i and ignore instr_ready_i for flushed entries.
REQ-027 SHALL not issue new requests while outstanding + discard = DEPTH; counters never overflow or underflow.
REQ-028 SHALL treat back-to-back redirects as cumulative: the latest redirect_pc_i wins and the discard count accumulates.

Reset
REQ-029 SHALL on rst: fetch-PC and response-PC = RESET_PC, buffer empty, outstanding = 0, discard = 0.
REQ-030 SHALL drive during reset imem_req_o=0, instr_valid_o=0, imem_addr_o=RESET_PC, instr_data_o=0, instr_pc_o=0.
REQ-031 SHALL ignore responses to requests granted before a mid-operation reset; the memory side is reset together with this block.

Structure
REQ-032 SHALL take XLEN=32, INSTR_W=32 and the default RESET_PC from the shared riscv_pkg package.
REQ-033 SHALL implement the buffer as sub-module fetch_fifo (DEPTH entries of {pc,instr}, push/pop/flush, full/empty).

Verification
REQ-034 Reset, imem always grants, 1-cycle rvalid -> addresses 0,4,8,...; instr_pc_o 0,4,8 with matching data; instr_valid_o continuous.
REQ-035 instr_ready_i=0 for 10 cycles -> exactly 2 requests issued, imem_req_o low, head PC=0 held; release -> stream resumes at PC 8.
REQ-036 2 requests outstanding, redirect to 0x100 -> 2 responses dropped; next visible instr_pc_o=0x100, instr_data_o equals mem[0x100].
REQ-037 imem_gnt_i low 5 cycles -> imem_addr_o stable at 0x8; redirect during stall -> next cycle addr=0x200, no spurious push.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> instr_pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 rst asserted mid-stream with 2 outstanding -> outputs zero immediately; after release fetch restarts at RESET_PC, no stale instructions.
